// File: rtl/tt_sweep_checker.sv
// Exhaustive stimulus/capture stage for an N_IN-input, single-output combinational function:
// sweeps every input pattern, records the truth table, ones count and CRC-16 signature, then derives input support.
module tt_sweep_checker #(
  parameter int          N_IN       = 8,
  parameter logic [15:0] SIG_POLY   = 16'h1021,
  parameter logic [15:0] SIG_INIT   = 16'hFFFF,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            y0,
  output logic [N_IN-1:0] x,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_cnt,
  output logic [15:0]     sig,
  output logic            sig_ok,
  output logic [N_IN-1:0] support
);

  localparam int DEPTH = 1 << N_IN;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_ANALYZE, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [N_IN-1:0]   cnt_reg;
  logic [DEPTH-1:0]  tt_reg;
  logic [N_IN:0]     ones_reg;
  logic [15:0]       sig_reg;
  logic [15:0]       sig_next;
  logic [N_IN-1:0]   support_reg;
  logic [N_IN-1:0]   dep_hit;
  logic              cnt_last;
  logic              accept;

  assign cnt_last = &cnt_reg;
  assign accept   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start) state_next = S_SWEEP;
      S_SWEEP:   if (cnt_last) state_next = S_ANALYZE;
      S_ANALYZE: if (cnt_last) state_next = S_DONE;
      S_DONE:    if (start) state_next = S_SWEEP;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output logic; x is only non-zero while patterns are being applied
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    x    = '0;
    case (state_reg)
      S_SWEEP: begin
        busy = 1'b1;
        x    = cnt_reg;
      end
      S_ANALYZE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign sig_next = {sig_reg[14:0], 1'b0} ^ ((sig_reg[15] ^ y0) ? SIG_POLY : 16'h0000);

  // Input i matters if flipping it from 0 to 1 at address cnt changes the output
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_dep
      logic [N_IN-1:0] partner;
      assign partner     = cnt_reg | (N_IN'(1) << gi);
      assign dep_hit[gi] = ~cnt_reg[gi] & (tt_reg[cnt_reg] ^ tt_reg[partner]);
    end
  endgenerate

  // Datapath; the counter wraps naturally to 0 on the last sweep pattern, seeding the analysis pass
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      tt_reg      <= '0;
      ones_reg    <= '0;
      sig_reg     <= SIG_INIT;
      support_reg <= '0;
    end else if (accept) begin
      cnt_reg     <= '0;
      ones_reg    <= '0;
      sig_reg     <= SIG_INIT;
      support_reg <= '0;
    end else if (state_reg == S_SWEEP) begin
      tt_reg[cnt_reg] <= y0;
      ones_reg        <= ones_reg + (N_IN+1)'(y0);
      sig_reg         <= sig_next;
      cnt_reg         <= cnt_reg + 1'b1;
    end else if (state_reg == S_ANALYZE) begin
      support_reg <= support_reg | dep_hit;
      cnt_reg     <= cnt_reg + 1'b1;
    end
  end

  assign ones_cnt = ones_reg;
  assign sig      = sig_reg;
  assign support  = support_reg;
  assign sig_ok   = done && (sig_reg == GOLDEN_SIG);

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: several benchmark functions, latency, restart, mid-run reset and golden compare.
module tb_tt_sweep_checker;

  function automatic logic f_model(input int mode, input logic [7:0] v);
    case (mode)
      1:       return v[0];
      2:       return v[7] ^ v[2];
      3:       return &v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] crc_model(input int mode);
    logic [15:0] s;
    logic        b;
    s = 16'hFFFF;
    for (int k = 0; k < 256; k++) begin
      b = f_model(mode, 8'(k));
      s = {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  localparam logic [15:0] AND_SIG = crc_model(3);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       y0;
  logic [7:0] x;
  logic       busy, done, sig_ok;
  logic [8:0] ones_cnt;
  logic [15:0] sig;
  logic [7:0] support;
  int         mode = 0;

  logic [7:0] x_g, x_w, sup_g, sup_w;
  logic       busy_g, busy_w, done_g, done_w, ok_g, ok_w;
  logic [8:0] ones_g, ones_w;
  logic [15:0] sig_g, sig_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always_comb y0 = f_model(mode, x);

  tt_sweep_checker dut (
    .clk(clk), .rst(rst), .start(start), .y0(y0), .x(x), .busy(busy), .done(done),
    .ones_cnt(ones_cnt), .sig(sig), .sig_ok(sig_ok), .support(support)
  );

  tt_sweep_checker #(.GOLDEN_SIG(AND_SIG)) dut_g (
    .clk(clk), .rst(rst), .start(start), .y0(&x_g), .x(x_g), .busy(busy_g), .done(done_g),
    .ones_cnt(ones_g), .sig(sig_g), .sig_ok(ok_g), .support(sup_g)
  );

  tt_sweep_checker #(.GOLDEN_SIG(AND_SIG ^ 16'h0001)) dut_w (
    .clk(clk), .rst(rst), .start(start), .y0(&x_w), .x(x_w), .busy(busy_w), .done(done_w),
    .ones_cnt(ones_w), .sig(sig_w), .sig_ok(ok_w), .support(sup_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_ones"}, 32'(ones_cnt), 0);
    chk({tag, "_sig"}, 32'(sig), 32'hFFFF);
    chk({tag, "_sigok"}, 32'(sig_ok), 0);
  endtask

  // One sweep with function `m`; optional start re-pulse and reset injection at busy-cycle index
  task automatic run(input int m, input int restart_at, input int rst_at,
                     input logic [8:0] exp_ones, input logic [7:0] exp_sup);
    int lat, n, xerr;
    logic [7:0] exp_x;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_drop", 32'(done), 0);
    chk("busy_rise", 32'(busy), 1);
    lat = 1; n = 0; xerr = 0;
    while (!done && lat < 2000) begin
      if (rst_at >= 0 && n == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state($sformatf("rst@%0d", rst_at));
        chk("rst_sup", 32'(support), 0);
        return;
      end
      start = (n == restart_at);
      if (busy) begin
        exp_x = (n < 256) ? 8'(n) : 8'h00;
        if (x !== exp_x) xerr++;
        n++;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk($sformatf("m%0d_latency", m), 32'(lat), 513);
    chk($sformatf("m%0d_busycyc", m), 32'(n), 512);
    chk($sformatf("m%0d_xseq_errs", m), 32'(xerr), 0);
    chk($sformatf("m%0d_ones", m), 32'(ones_cnt), 32'(exp_ones));
    chk($sformatf("m%0d_support", m), 32'(support), 32'(exp_sup));
    chk($sformatf("m%0d_sig", m), 32'(sig), 32'(crc_model(m)));
    chk($sformatf("m%0d_sigok", m), 32'(sig_ok), 32'(crc_model(m) == 16'h0000));
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("m%0d_done_held", m), 32'({done, busy}), 32'h2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    chk("reset_sup", 32'(support), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_sigok_g", 32'(ok_g), 0);

    run(0, -1, -1, 9'd0,   8'h00);
    run(1, -1, -1, 9'd128, 8'h01);
    run(2, -1, -1, 9'd128, 8'h84);
    run(3, -1, -1, 9'd1,   8'hFF);
    chk("and_golden_ok", 32'(ok_g), 1);
    chk("and_golden_sig", 32'(sig_g), 32'(AND_SIG));
    chk("and_wrong_ok", 32'(ok_w), 0);
    run(3, 50, -1, 9'd1, 8'hFF);
    chk("restart_golden_ok", 32'(ok_g), 1);

    run(2, -1, 100, 9'd0, 8'h00);
    run(2, -1, 300, 9'd0, 8'h00);
    run(2, -1, -1, 9'd128, 8'h84);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
